// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode/funct constants, fetch FSM states and
// instruction-field helpers used by ifetch and by core decode.
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;

  localparam logic [5:0] FUNCT_JR = 6'h08;

  typedef enum logic {
    FETCH = 1'b0,
    EXEC  = 1'b1
  } fetch_state_e;

  // Word-aligned, sign-extended branch displacement.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/npc_calc.sv
// Next-PC computation: branch, jump, jr and sequential targets from the
// instruction register and the core's zero flag / register port A.
module npc_calc
  import cpu_pkg::*;
(
  input  logic [31:0] ir,
  input  logic [31:0] pc,
  input  logic        is_zero,
  input  logic [31:0] da,
  output logic [31:0] next_pc,
  output logic [31:0] pc_plus4
);

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] jr_target;
  logic        branch_taken;

  assign opcode        = ir[31:26];
  assign funct         = ir[5:0];
  assign pc_plus4      = pc + 32'd4;
  assign branch_target = pc_plus4 + branch_offset(ir[15:0]);
  assign jump_target   = {pc_plus4[31:28], ir[25:0], 2'b00};
  // jr silently drops the low two bits of the register value.
  assign jr_target     = da & ~32'h3;

  assign branch_taken = ((opcode == OP_BEQ) &&  is_zero) ||
                        ((opcode == OP_BNE) && !is_zero);

  always_comb begin
    if (branch_taken) begin
      next_pc = branch_target;
    end else if ((opcode == OP_J) || (opcode == OP_JAL)) begin
      next_pc = jump_target;
    end else if ((opcode == OP_RTYPE) && (funct == FUNCT_JR)) begin
      next_pc = jr_target;
    end else begin
      next_pc = pc_plus4;
    end
  end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch/sequencing stage: owns the PC, fetches over a
// valid/ready handshake and presents decoded fields to the core for one cycle.
module ifetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        is_zero,
  input  logic [31:0] Da,
  output logic        instr_valid,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [15:0] immediate,
  output logic [31:0] new_PC,
  output logic [31:0] pc
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q;
  logic [31:0]  ir_q;
  logic [31:0]  next_pc;
  logic [31:0]  pc_plus4;
  logic         ir_load;
  logic         pc_load;

  npc_calc u_npc_calc (
    .ir       (ir_q),
    .pc       (pc_q),
    .is_zero  (is_zero),
    .da       (Da),
    .next_pc  (next_pc),
    .pc_plus4 (pc_plus4)
  );

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    ir_load     = 1'b0;
    pc_load     = 1'b0;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    case (state_q)
      FETCH: begin
        imem_req = run && !reset;
        if (run && imem_ready) begin
          ir_load = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        // run is deliberately ignored here so a fetched instruction always retires.
        instr_valid = 1'b1;
        pc_load     = 1'b1;
        state_d     = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      if (ir_load) ir_q <= imem_rdata;
      if (pc_load) pc_q <= next_pc;
    end
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign new_PC    = pc_plus4;
  assign opcode    = ir_q[31:26];
  assign rs        = ir_q[25:21];
  assign rt        = ir_q[20:16];
  assign rd        = ir_q[15:11];
  assign immediate = ir_q[15:0];
  assign funct     = ir_q[5:0];

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch and npc_calc: expected fetch addresses are queued
// when an instruction is returned and compared when the next request appears.
module tb_ifetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        is_zero;
  logic [31:0] Da;

  logic        imem_req, instr_valid;
  logic [31:0] imem_addr, new_PC, pc;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] immediate;

  logic        d2_req, d2_valid;
  logic [31:0] d2_addr, d2_new_pc, d2_pc;
  logic [5:0]  d2_opcode, d2_funct;
  logic [4:0]  d2_rs, d2_rt, d2_rd;
  logic [15:0] d2_imm;

  logic [31:0] u_ir, u_pc, u_da, u_next, u_p4;
  logic        u_iz;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  ifetch #(.RESET_PC(32'h0000_0000)) u_dut (
    .clk(clk), .reset(reset), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .is_zero(is_zero), .Da(Da),
    .instr_valid(instr_valid), .opcode(opcode), .funct(funct),
    .rs(rs), .rt(rt), .rd(rd), .immediate(immediate),
    .new_PC(new_PC), .pc(pc)
  );

  ifetch #(.RESET_PC(32'h0000_0100)) u_dut2 (
    .clk(clk), .reset(reset), .run(run),
    .imem_req(d2_req), .imem_addr(d2_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .is_zero(is_zero), .Da(Da),
    .instr_valid(d2_valid), .opcode(d2_opcode), .funct(d2_funct),
    .rs(d2_rs), .rt(d2_rt), .rd(d2_rd), .immediate(d2_imm),
    .new_PC(d2_new_pc), .pc(d2_pc)
  );

  npc_calc u_npc (
    .ir(u_ir), .pc(u_pc), .is_zero(u_iz), .da(u_da),
    .next_pc(u_next), .pc_plus4(u_p4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_next(input logic [31:0] instr, input logic [31:0] cur,
                                             input logic iz, input logic [31:0] da);
    logic [31:0] p4;
    logic [5:0]  op;
    p4 = cur + 32'd4;
    op = instr[31:26];
    if ((op == 6'h04 && iz) || (op == 6'h05 && !iz))
      return p4 + {{14{instr[15]}}, instr[15:0], 2'b00};
    if (op == 6'h02 || op == 6'h03)
      return {p4[31:28], instr[25:0], 2'b00};
    if (op == 6'h00 && instr[5:0] == 6'h08)
      return {da[31:2], 2'b00};
    return p4;
  endfunction

  // Entered in FETCH just after an edge; leaves the DUT mid-EXEC.
  task automatic issue(input string tag, input logic [31:0] instr,
                       input logic iz, input logic [31:0] da);
    logic [31:0] exp_pc;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
      exp_pc = 32'hxxxx_xxxx;
    end else begin
      exp_pc = sb.pop_front();
    end
    check({tag, "_req"}, {31'd0, imem_req}, 32'd1);
    check({tag, "_addr"}, imem_addr, exp_pc);
    check({tag, "_valid_lo"}, {31'd0, instr_valid}, 32'd0);
    imem_rdata = instr;
    imem_ready = 1'b1;
    sb.push_back(model_next(instr, exp_pc, iz, da));
    @(posedge clk); #1;
    imem_ready = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    is_zero    = iz;
    Da         = da;
    check({tag, "_valid_hi"}, {31'd0, instr_valid}, 32'd1);
    check({tag, "_req_lo"}, {31'd0, imem_req}, 32'd0);
    check({tag, "_new_pc"}, new_PC, exp_pc + 32'd4);
    check({tag, "_fields"}, {opcode, rs, rt, immediate}, instr);
    check({tag, "_rd_funct"}, {21'd0, rd, funct}, {21'd0, instr[15:11], instr[5:0]});
  endtask

  task automatic close();
    @(posedge clk); #1;
  endtask

  task automatic run_instr(input string tag, input logic [31:0] instr,
                           input logic iz, input logic [31:0] da);
    issue(tag, instr, iz, da);
    close();
  endtask

  localparam logic [31:0] ADDI = 32'h2001_0005;

  typedef struct {
    logic [31:0] ir, pc, da, exp_next, exp_p4;
    logic        iz;
  } npc_vec_t;

  initial begin
    npc_vec_t vecs[6];
    logic [31:0] hold_addr;

    vecs[0] = '{ir: 32'h1400_FFFE, pc: 32'h0000_0000, da: 32'h0, iz: 1'b0,
                exp_next: 32'hFFFF_FFFC, exp_p4: 32'h0000_0004};
    vecs[1] = '{ir: 32'h1400_FFFE, pc: 32'h0000_0000, da: 32'h0, iz: 1'b1,
                exp_next: 32'h0000_0004, exp_p4: 32'h0000_0004};
    vecs[2] = '{ir: 32'h1000_0001, pc: 32'hFFFF_FFFC, da: 32'h0, iz: 1'b1,
                exp_next: 32'h0000_0004, exp_p4: 32'h0000_0000};
    vecs[3] = '{ir: 32'h0BFF_FFFF, pc: 32'hF000_0000, da: 32'h0, iz: 1'b0,
                exp_next: 32'hFFFF_FFFC, exp_p4: 32'hF000_0004};
    vecs[4] = '{ir: 32'hFC00_0008, pc: 32'h0000_0100, da: 32'h5555_5555, iz: 1'b0,
                exp_next: 32'h0000_0104, exp_p4: 32'h0000_0104};
    vecs[5] = '{ir: 32'h03E0_0020, pc: 32'h0000_0200, da: 32'h1234_5678, iz: 1'b1,
                exp_next: 32'h0000_0204, exp_p4: 32'h0000_0204};
    foreach (vecs[i]) begin
      u_ir = vecs[i].ir; u_pc = vecs[i].pc; u_da = vecs[i].da; u_iz = vecs[i].iz;
      #1;
      check($sformatf("npc_next_%0d", i), u_next, vecs[i].exp_next);
      check($sformatf("npc_p4_%0d", i), u_p4, vecs[i].exp_p4);
    end

    reset = 1'b1; run = 1'b1; imem_ready = 1'b0; imem_rdata = 32'h0;
    is_zero = 1'b0; Da = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_pc", pc, 32'h0);
    check("rst_fields", {opcode, rs, rt, immediate}, 32'h0);
    check("rst_pc2", d2_pc, 32'h100);
    reset = 1'b0;
    #1;
    sb.push_back(32'h0);

    run_instr("addi0", ADDI, 1'b0, 32'h0);
    run_instr("addi1", ADDI, 1'b0, 32'h0);
    run_instr("addi2", ADDI, 1'b0, 32'h0);
    run_instr("j_10", 32'h0800_0004, 1'b0, 32'h0);
    run_instr("beq_t", 32'h1022_FFFC, 1'b1, 32'h0);
    check("beq_t_target", sb[0], 32'h0000_0004);
    run_instr("j_10b", 32'h0800_0004, 1'b0, 32'h0);
    run_instr("beq_nt", 32'h1022_FFFC, 1'b0, 32'h0);
    run_instr("j_20", 32'h0800_0008, 1'b0, 32'h0);
    issue("jal", 32'h0C00_0100, 1'b0, 32'h0);
    check("jal_link", new_PC, 32'h0000_0024);
    close();
    check("jal_target", imem_addr, 32'h0000_0400);
    run_instr("jr", 32'h03E0_0008, 1'b0, 32'h0000_1237);
    check("jr_target", imem_addr, 32'h0000_1234);

    hold_addr = imem_addr;
    for (int w = 0; w < 3; w++) begin
      imem_rdata = 32'hFFFF_FFFF;
      check($sformatf("wait%0d_req", w), {31'd0, imem_req}, 32'd1);
      check($sformatf("wait%0d_addr", w), imem_addr, hold_addr);
      check($sformatf("wait%0d_valid", w), {31'd0, instr_valid}, 32'd0);
      check($sformatf("wait%0d_ir", w), {26'd0, opcode}, 32'd0);
      @(posedge clk); #1;
    end
    run_instr("addi_wait", ADDI, 1'b0, 32'h0);
    check("after_wait_valid", {31'd0, instr_valid}, 32'd0);

    run_instr("jr_top", 32'h03E0_0008, 1'b0, 32'hFFFF_FFFC);
    issue("addi_wrap", ADDI, 1'b0, 32'h0);
    check("wrap_link", new_PC, 32'h0);
    close();
    check("wrap_addr", imem_addr, 32'h0);

    run = 1'b0;
    #1;
    check("run_lo_req", {31'd0, imem_req}, 32'd0);
    imem_ready = 1'b1;
    @(posedge clk); #1;
    check("run_lo_valid", {31'd0, instr_valid}, 32'd0);
    check("run_lo_pc", pc, 32'h0);
    imem_ready = 1'b0;
    run = 1'b1;
    #1;

    run_instr("j_40", 32'h0800_0010, 1'b0, 32'h0);
    issue("nop_40", 32'h0000_0000, 1'b0, 32'h0);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_valid", {31'd0, instr_valid}, 32'd0);
    check("mid_rst_pc", pc, 32'h0);
    check("mid_rst_req", {31'd0, imem_req}, 32'd0);
    check("mid_rst_ir", {26'd0, opcode}, 32'd0);
    check("mid_rst_valid2", {31'd0, d2_valid}, 32'd0);
    check("mid_rst_pc2", d2_pc, 32'h100);
    sb.delete();
    sb.push_back(32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("restart_req2", {31'd0, d2_req}, 32'd1);
    check("restart_addr2", d2_addr, 32'h100);
    run_instr("restart", ADDI, 1'b0, 32'h0);
    check("restart_next", imem_addr, 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

endmodule
